bus_memory: RTL and testbench

BUS_MEMORY -- requirements
Module: bus_memory

---
 rtl/bus_memory.sv | 139 +++++++++++++
 tb/tb_bus_memory.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_memory.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | bus_memory : single-port word memory behind a valid/ready request bus,   |
// |              with programmable wait states and a write-protected region. |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module bus_memory #(
   parameter int unsigned DEPTH       = 2**16,
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned ROM_BASE    = 16'hE000,
   parameter int unsigned ROM_SIZE    = 16'h2000,
   parameter string       DATA_FILE   = "data.mif"
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [$clog2(DEPTH)-1:0] req_addr,
   input  logic [WIDTH-1:0]         req_wdata,
   output logic                     rsp_valid,
   output logic [WIDTH-1:0]         rsp_rdata,
   output logic                     rsp_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_WAIT = 2'd1;
   localparam logic [1:0] c_RESP = 2'd2;

   localparam logic [CW-1:0] c_CNT_LOAD = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
   // One extra bit so a region ending at the top of memory does not wrap to 0.
   localparam logic [AW:0]   c_ROM_LO   = ROM_BASE[AW:0];
   localparam logic [AW:0]   c_ROM_HI   = c_ROM_LO + ROM_SIZE[AW:0];

   logic [WIDTH-1:0] r_mem [DEPTH];

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic             r_we;
   logic [AW-1:0]    r_addr;
   logic [WIDTH-1:0] r_wdata;
   logic             r_ready;
   logic             r_rsp_valid;
   logic             r_rsp_err;
   logic [WIDTH-1:0] r_rsp_rdata;

   logic             w_accept;
   logic             w_enter_resp;
   logic             w_we;
   logic [AW-1:0]    w_addr;
   logic [WIDTH-1:0] w_wdata;
   logic             w_prot;
   logic             w_commit;

   // With no wait states RESP is entered on the accept edge, so the live
   // request is used there; afterwards only the held copy is consulted.
   always_comb begin
      w_accept     = (r_state == c_IDLE) && req_valid;
      w_we         = (r_state == c_IDLE) ? req_we    : r_we;
      w_addr       = (r_state == c_IDLE) ? req_addr  : r_addr;
      w_wdata      = (r_state == c_IDLE) ? req_wdata : r_wdata;
      w_prot       = (ROM_SIZE != 0) && ({1'b0, w_addr} >= c_ROM_LO)
                                     && ({1'b0, w_addr} <  c_ROM_HI);
      w_state_nxt  = r_state;
      w_enter_resp = 1'b0;
      case (r_state)
         c_IDLE: begin
            if (req_valid) begin
               if (WAIT_STATES == 0) begin
                  w_state_nxt  = c_RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  w_state_nxt  = c_WAIT;
               end
            end
         end
         c_WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt  = c_RESP;
               w_enter_resp = 1'b1;
            end
         end
         c_RESP:  w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
      w_commit = w_enter_resp && w_we && !w_prot;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= c_IDLE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_ready     <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= (w_state_nxt == c_IDLE);
         if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= c_CNT_LOAD;
         end else if ((r_state == c_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
         r_rsp_valid <= w_enter_resp;
         r_rsp_err   <= w_enter_resp && w_we && w_prot;
         if (w_enter_resp) begin
            r_rsp_rdata <= w_commit ? w_wdata : r_mem[w_addr];
         end else begin
            r_rsp_rdata <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_commit) begin
         r_mem[w_addr] <= w_wdata;
      end
   end

   assign req_ready = r_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_memory.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_bus_memory : directed bench for bus_memory, one instance with zero    |
// |                 and one with three wait states, checked against a model. |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_bus_memory;

   localparam int WS0    = 0;
   localparam int WS1    = 3;
   localparam int ROM_LO = 'hE000;
   localparam int ROM_HI = 'h10000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst [2];
   logic       rv  [2];
   logic       rwe [2];
   logic [15:0] ra [2];
   logic [7:0] rwd [2];
   logic       rdy [2];
   logic       vld [2];
   logic [7:0] rd  [2];
   logic       err [2];

   bus_memory #(.WAIT_STATES(WS0), .DATA_FILE("")) u_dut0 (
      .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_ready(rdy[0]),
      .req_we(rwe[0]), .req_addr(ra[0]), .req_wdata(rwd[0]),
      .rsp_valid(vld[0]), .rsp_rdata(rd[0]), .rsp_err(err[0]));

   bus_memory #(.WAIT_STATES(WS1), .DATA_FILE("")) u_dut1 (
      .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_ready(rdy[1]),
      .req_we(rwe[1]), .req_addr(ra[1]), .req_wdata(rwd[1]),
      .rsp_valid(vld[1]), .rsp_rdata(rd[1]), .rsp_err(err[1]));

   int n_cmp = 0;
   int n_bad = 0;
   bit chk   = 1'b0;

   task automatic cmp(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, got, exp, $time);
      end
   endtask

   task automatic tmo(input string nm, input int k);
      n_cmp++;
      n_bad++;
      $display("FAIL %s dut%0d: got timeout expected response at %0t", nm, k, $time);
   endtask

   // Transaction-level model: a request accepted at edge n completes at edge
   // n+WS (commit + response) and the bus is free again one edge later.
   logic [7:0] mm [2][65536];
   bit         kn [2][65536];
   bit         m_busy [2];
   int         m_fin  [2];
   bit         m_we   [2];
   int         m_a    [2];
   logic [7:0] m_d    [2];
   bit         e_rdy [2] = '{1'b0, 1'b0};
   bit         e_vld [2];
   bit         e_err [2];
   bit         e_rdk [2];
   logic [7:0] e_rd  [2];
   int         cyc = 0;

   always @(posedge clk) begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
         bit rdy_before;
         bit prot;
         rdy_before = e_rdy[k];
         if (rst[k]) begin
            m_busy[k] = 1'b0;
            e_rdy[k]  = 1'b1;
            e_vld[k]  = 1'b0;
            e_err[k]  = 1'b0;
            e_rd[k]   = 8'h00;
            e_rdk[k]  = 1'b1;
         end else begin
            e_vld[k] = 1'b0;
            e_err[k] = 1'b0;
            e_rd[k]  = 8'h00;
            e_rdk[k] = 1'b1;
            if (rdy_before && !m_busy[k] && rv[k]) begin
               m_busy[k] = 1'b1;
               m_fin[k]  = cyc + ((k == 0) ? WS0 : WS1);
               m_we[k]   = rwe[k];
               m_a[k]    = int'(ra[k]);
               m_d[k]    = rwd[k];
            end
            if (m_busy[k] && cyc == m_fin[k]) begin
               e_vld[k] = 1'b1;
               prot = (m_a[k] >= ROM_LO) && (m_a[k] < ROM_HI);
               if (m_we[k] && !prot) begin
                  mm[k][m_a[k]] = m_d[k];
                  kn[k][m_a[k]] = 1'b1;
                  e_rd[k]       = m_d[k];
               end else begin
                  e_rd[k]  = mm[k][m_a[k]];
                  e_rdk[k] = kn[k][m_a[k]];
                  e_err[k] = m_we[k];
               end
            end else if (m_busy[k] && cyc == m_fin[k] + 1) begin
               m_busy[k] = 1'b0;
            end
            e_rdy[k] = !m_busy[k];
         end
      end
   end

   always @(negedge clk) begin
      if (chk) begin
         for (int k = 0; k < 2; k++) begin
            cmp("req_ready", k, rdy[k], e_rdy[k]);
            cmp("rsp_valid", k, vld[k], e_vld[k]);
            cmp("rsp_err",   k, err[k], e_err[k]);
            if (e_rdk[k]) cmp("rsp_rdata", k, rd[k], e_rd[k]);
         end
      end
   end

   task automatic txn(input int k, input bit we, input logic [15:0] a, input logic [7:0] d,
                      input bit scr, output logic [7:0] grd, output logic gerr, output int lat);
      int t;
      grd  = 8'h00;
      gerr = 1'b0;
      lat  = -1;
      @(negedge clk);
      rv[k] = 1'b1; rwe[k] = we; ra[k] = a; rwd[k] = d;
      t = 0;
      while (rdy[k] !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         tmo("accept", k);
         rv[k] = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      rv[k] = 1'b0;
      lat = 1;
      while (vld[k] !== 1'b1 && lat < 50) begin
         if (scr) begin
            ra[k] = 16'($urandom); rwd[k] = 8'($urandom); rwe[k] = ~we;
         end
         @(negedge clk);
         lat++;
      end
      if (lat >= 50) begin
         tmo("response", k);
         return;
      end
      grd  = rd[k];
      gerr = err[k];
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog dut0: got no finish expected finish at %0t", $time);
      $fatal(1);
   end

   initial begin
      logic [7:0] g;
      logic       ge;
      int         lat;
      int         acc1, acc2, vfirst, lows, vc, t;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; rv[k] = 1'b0; rwe[k] = 1'b0; ra[k] = '0; rwd[k] = '0;
      end
      u_dut0.r_mem[16'hFFFF] = 8'hEA;
      mm[0][16'hFFFF] = 8'hEA;
      kn[0][16'hFFFF] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk = 1'b1;
      cmp("reset_ready", 0, rdy[0], 1);
      cmp("reset_valid", 0, vld[0], 0);
      cmp("reset_ready", 1, rdy[1], 1);
      cmp("reset_rdata", 1, rd[1], 0);
      rst[0] = 1'b0; rst[1] = 1'b0;

      // Zero wait states: write then read back
      txn(0, 1'b1, 16'h0200, 8'hA5, 1'b0, g, ge, lat);
      cmp("w0200_lat", 0, lat, 1);  cmp("w0200_err", 0, ge, 0);  cmp("w0200_echo", 0, g, 8'hA5);
      txn(0, 1'b0, 16'h0200, 8'h00, 1'b0, g, ge, lat);
      cmp("r0200_lat", 0, lat, 1);  cmp("r0200_data", 0, g, 8'hA5); cmp("r0200_err", 0, ge, 0);

      // Three wait states: latency, ready-low window, accept spacing
      txn(1, 1'b1, 16'h0300, 8'h3C, 1'b0, g, ge, lat);
      cmp("w0300_lat", 1, lat, 4);
      acc1 = -1; acc2 = -1; vfirst = -1; lows = 0;
      @(negedge clk);
      rv[1] = 1'b1; rwe[1] = 1'b0; ra[1] = 16'h0300;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         if (vld[1] === 1'b1 && vfirst < 0) vfirst = i;
         if (acc1 >= 0 && acc2 < 0 && rdy[1] !== 1'b1) lows++;
         if (rdy[1] === 1'b1) begin
            if (acc1 < 0) acc1 = i;
            else if (acc2 < 0) acc2 = i;
         end
      end
      rv[1] = 1'b0;
      cmp("accept_gap", 1, acc2 - acc1, 5);
      cmp("ready_low",  1, lows, 4);
      cmp("valid_lat",  1, vfirst - acc1, 4);
      repeat (6) @(negedge clk);

      // Protected region
      txn(0, 1'b1, 16'hE000, 8'h55, 1'b0, g, ge, lat);
      cmp("wE000_err", 0, ge, 1);
      txn(0, 1'b1, 16'hFFFF, 8'h55, 1'b0, g, ge, lat);
      cmp("wFFFF_err", 0, ge, 1);   cmp("wFFFF_data", 0, g, 8'hEA);
      txn(0, 1'b0, 16'hFFFF, 8'h00, 1'b0, g, ge, lat);
      cmp("rFFFF_data", 0, g, 8'hEA); cmp("rFFFF_err", 0, ge, 0);
      txn(0, 1'b1, 16'hDFFF, 8'h77, 1'b0, g, ge, lat);
      cmp("wDFFF_err", 0, ge, 0);
      txn(0, 1'b0, 16'hDFFF, 8'h00, 1'b0, g, ge, lat);
      cmp("rDFFF_data", 0, g, 8'h77);

      // Reset while waiting aborts an uncommitted write
      txn(1, 1'b1, 16'h0010, 8'h00, 1'b0, g, ge, lat);
      @(negedge clk);
      rv[1] = 1'b1; rwe[1] = 1'b1; ra[1] = 16'h0010; rwd[1] = 8'h11;
      t = 0;
      while (rdy[1] !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) tmo("abort_accept", 1);
      @(posedge clk);
      @(negedge clk);
      rv[1] = 1'b0; rst[1] = 1'b1;
      @(negedge clk);
      rst[1] = 1'b0;
      vc = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (vld[1] === 1'b1) vc++;
      end
      cmp("abort_no_valid", 1, vc, 0);
      txn(1, 1'b0, 16'h0010, 8'h00, 1'b0, g, ge, lat);
      cmp("r0010_data", 1, g, 8'h00);

      // Inputs changing after accept are ignored
      txn(1, 1'b1, 16'h0020, 8'h9A, 1'b1, g, ge, lat);
      cmp("w0020_echo", 1, g, 8'h9A);
      txn(1, 1'b0, 16'h0020, 8'h00, 1'b1, g, ge, lat);
      cmp("r0020_data", 1, g, 8'h9A);
      txn(0, 1'b1, 16'h0040, 8'hC3, 1'b1, g, ge, lat);
      txn(0, 1'b0, 16'h0040, 8'h00, 1'b1, g, ge, lat);
      cmp("r0040_data", 0, g, 8'hC3);

      // Reset wins over a simultaneous request
      @(negedge clk);
      rst[0] = 1'b1; rv[0] = 1'b1; rwe[0] = 1'b0; ra[0] = 16'h0200;
      @(negedge clk);
      cmp("rstpri_no_valid", 0, vld[0], 0);
      cmp("rstpri_ready",    0, rdy[0], 1);
      rst[0] = 1'b0;
      @(negedge clk);
      rv[0] = 1'b0;
      cmp("rstpri_valid", 0, vld[0], 1);
      cmp("rstpri_data",  0, rd[0], 8'hA5);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
